// File: rtl/player_life_ctrl.sv
// Player life-cycle sequencer: IDLE -> RESPAWN -> ALIVE -> DYING -> WAIT/GAME_OVER.
// Optional macro EXTRA_LIFE_EN enables extra_life awards; without it extra_life is ignored.
module player_life_ctrl #(
  parameter int INIT_LIVES     = 3,
  parameter int MAX_LIVES      = 5,
  parameter int DEATH_FRAMES   = 60,
  parameter int RESPAWN_FRAMES = 30,
  parameter int INVULN_FRAMES  = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       game_start,
  input  logic       player_died,
  input  logic       extra_life,
  output logic       player_freeze,
  output logic       player_respawn,
  output logic       death_anim,
  output logic       invulnerable,
  output logic [2:0] lives,
  output logic       game_over,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ALIVE     = 3'd1,
    S_DYING     = 3'd2,
    S_WAIT      = 3'd3,
    S_RESPAWN   = 3'd4,
    S_GAME_OVER = 3'd5
  } state_t;

  // Zero-length phases would never terminate, so they are stretched to one frame.
  localparam int DF   = (DEATH_FRAMES   < 1) ? 1 : DEATH_FRAMES;
  localparam int RF   = (RESPAWN_FRAMES < 1) ? 1 : RESPAWN_FRAMES;
  localparam int IF   = (INVULN_FRAMES  < 1) ? 1 : INVULN_FRAMES;
  localparam int MAXF = (DF > RF) ? ((DF > IF) ? DF : IF) : ((RF > IF) ? RF : IF);
  localparam int CW   = (MAXF < 2) ? 1 : $clog2(MAXF + 1);
  localparam int ML   = (MAX_LIVES > 7) ? 7 : ((MAX_LIVES < 0) ? 0 : MAX_LIVES);
  localparam int IL   = (INIT_LIVES > ML) ? ML : ((INIT_LIVES < 0) ? 0 : INIT_LIVES);

  localparam logic [CW-1:0] DF_LAST = CW'(DF - 1);
  localparam logic [CW-1:0] RF_LAST = CW'(RF - 1);
  localparam logic [CW-1:0] IV_LOAD = CW'(IF);
  localparam logic [2:0]    MAX_L   = 3'(ML);
  localparam logic [2:0]    INIT_L  = 3'(IL);

  state_t        state_reg, state_next;
  logic [2:0]    lives_reg, lives_next;
  logic [CW-1:0] frame_reg, frame_next;
  logic [CW-1:0] invuln_reg, invuln_next;
  logic          award, death;

`ifndef EXTRA_LIFE_EN
  logic unused_extra_life;
  assign unused_extra_life = extra_life;
`endif

  always_comb begin
    state_next  = state_reg;
    lives_next  = lives_reg;
    frame_next  = frame_reg;
    invuln_next = invuln_reg;
    award       = 1'b0;
`ifdef EXTRA_LIFE_EN
    award = extra_life && (state_reg == S_ALIVE || state_reg == S_DYING ||
                           state_reg == S_WAIT  || state_reg == S_RESPAWN);
`endif
    death = (state_reg == S_ALIVE) && player_died && (invuln_reg == '0);

    if (startOfFrame && invuln_reg != '0)
      invuln_next = invuln_reg - CW'(1);

    // An award coinciding with a death cancels out rather than saturating first.
    if (award && !death) begin
      if (lives_reg < MAX_L)
        lives_next = lives_reg + 3'd1;
    end else if (death && !award) begin
      if (lives_reg != 3'd0)
        lives_next = lives_reg - 3'd1;
    end

    case (state_reg)
      S_RESPAWN: begin
        state_next  = S_ALIVE;
        invuln_next = IV_LOAD;
      end
      S_ALIVE: begin
        if (death) begin
          state_next = S_DYING;
          frame_next = '0;
        end
      end
      S_DYING: begin
        if (startOfFrame) begin
          if (frame_reg == DF_LAST) begin
            frame_next = '0;
            state_next = (lives_next == 3'd0) ? S_GAME_OVER : S_WAIT;
          end else begin
            frame_next = frame_reg + CW'(1);
          end
        end
      end
      S_WAIT: begin
        if (startOfFrame) begin
          if (frame_reg == RF_LAST) begin
            frame_next = '0;
            state_next = S_RESPAWN;
          end else begin
            frame_next = frame_reg + CW'(1);
          end
        end
      end
      default: ;
    endcase

    if (game_start) begin
      state_next = S_RESPAWN;
      lives_next = INIT_L;
      frame_next = '0;
    end
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      lives_reg      <= 3'd0;
      frame_reg      <= '0;
      invuln_reg     <= '0;
      player_freeze  <= 1'b1;
      player_respawn <= 1'b0;
      death_anim     <= 1'b0;
      invulnerable   <= 1'b0;
      lives          <= 3'd0;
      game_over      <= 1'b0;
      state_dbg      <= 3'd0;
    end else begin
      state_reg      <= state_next;
      lives_reg      <= lives_next;
      frame_reg      <= frame_next;
      invuln_reg     <= invuln_next;
      player_freeze  <= (state_next != S_ALIVE);
      player_respawn <= (state_next == S_RESPAWN);
      death_anim     <= (state_next == S_DYING);
      invulnerable   <= (invuln_next != '0);
      lives          <= lives_next;
      game_over      <= (state_next == S_GAME_OVER);
      state_dbg      <= state_next;
    end
  end

endmodule

// File: tb/tb_player_life_ctrl.sv
// Directed bench for player_life_ctrl with default parameters; expectations depend on EXTRA_LIFE_EN.
module tb_player_life_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       startOfFrame;
  logic       game_start;
  logic       player_died;
  logic       extra_life;
  logic       player_freeze;
  logic       player_respawn;
  logic       death_anim;
  logic       invulnerable;
  logic [2:0] lives;
  logic       game_over;
  logic [2:0] state_dbg;

  int n_vec = 0;
  int n_err = 0;

`ifdef EXTRA_LIFE_EN
  localparam int SAT_LIVES   = 5;
  localparam int END_STATE   = 3;
  localparam int END_LIVES   = 1;
  localparam int END_GO      = 0;
`else
  localparam int SAT_LIVES   = 3;
  localparam int END_STATE   = 5;
  localparam int END_LIVES   = 0;
  localparam int END_GO      = 1;
`endif

  player_life_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame   (startOfFrame),
    .game_start     (game_start),
    .player_died    (player_died),
    .extra_life     (extra_life),
    .player_freeze  (player_freeze),
    .player_respawn (player_respawn),
    .death_anim     (death_anim),
    .invulnerable   (invulnerable),
    .lives          (lives),
    .game_over      (game_over),
    .state_dbg      (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
    end
  endtask

  // Wait out invulnerability from a fresh ALIVE entry, then die.
  task automatic kill();
    frames(90);
    player_died = 1'b1;
    tick();
    player_died = 1'b0;
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; game_start = 1'b0;
    player_died = 1'b0; extra_life = 1'b0;
    tick(); tick();
    check("rst_state", state_dbg, 0);
    check("rst_lives", lives, 0);
    check("rst_freeze", player_freeze, 1);
    check("rst_gameover", game_over, 0);
    check("rst_anim", death_anim, 0);
    check("rst_respawn", player_respawn, 0);
    check("rst_invuln", invulnerable, 0);
    reset = 1'b0;
    tick();
    check("idle_hold", state_dbg, 0);

    // New game: one-clk respawn pulse, then ALIVE and invulnerable.
    game_start = 1'b1; tick(); game_start = 1'b0;
    check("start_state", state_dbg, 4);
    check("start_respawn", player_respawn, 1);
    check("start_lives", lives, 3);
    check("start_freeze", player_freeze, 1);
    tick();
    check("alive_state", state_dbg, 1);
    check("alive_respawn", player_respawn, 0);
    check("alive_freeze", player_freeze, 0);
    check("alive_invuln", invulnerable, 1);

    // Death during invulnerability is dropped.
    frames(10);
    player_died = 1'b1; tick(); player_died = 1'b0;
    check("invuln_state", state_dbg, 1);
    check("invuln_lives", lives, 3);
    frames(79);
    check("invuln_f89", invulnerable, 1);
    frames(1);
    check("invuln_f90", invulnerable, 0);

    // First real death: 60 frames of animation then 30 frames of waiting.
    player_died = 1'b1; tick(); player_died = 1'b0;
    check("die_state", state_dbg, 2);
    check("die_lives", lives, 2);
    check("die_anim", death_anim, 1);
    check("die_freeze", player_freeze, 1);
    frames(59);
    check("die_f59_state", state_dbg, 2);
    check("die_f59_anim", death_anim, 1);
    frames(1);
    check("wait_state", state_dbg, 3);
    check("wait_anim", death_anim, 0);
    check("wait_freeze", player_freeze, 1);
    frames(29);
    check("wait_f29_state", state_dbg, 3);
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
    check("resp_state", state_dbg, 4);
    check("resp_pulse", player_respawn, 1);
    tick();
    check("resp_end_state", state_dbg, 1);
    check("resp_end_pulse", player_respawn, 0);
    check("resp_end_freeze", player_freeze, 0);
    check("resp_end_invuln", invulnerable, 1);

    // game_start mid-DYING restarts immediately.
    kill();
    check("die2_lives", lives, 1);
    frames(20);
    game_start = 1'b1; tick(); game_start = 1'b0;
    check("gs_dying_state", state_dbg, 4);
    check("gs_dying_lives", lives, 3);
    check("gs_dying_anim", death_anim, 0);
    tick();

    // Three deaths end the game.
    kill();
    check("go_d1_lives", lives, 2);
    frames(90);
    kill();
    check("go_d2_lives", lives, 1);
    frames(90);
    kill();
    check("go_d3_lives", lives, 0);
    check("go_d3_state", state_dbg, 2);
    frames(59);
    check("go_f59_state", state_dbg, 2);
    frames(1);
    check("go_state", state_dbg, 5);
    check("go_flag", game_over, 1);
    check("go_lives", lives, 0);
    check("go_freeze", player_freeze, 1);
    player_died = 1'b1; tick(); player_died = 1'b0;
    check("go_died_state", state_dbg, 5);
    check("go_died_lives", lives, 0);
    game_start = 1'b1; tick(); game_start = 1'b0;
    check("go_restart_state", state_dbg, 4);
    check("go_restart_lives", lives, 3);
    check("go_restart_pulse", player_respawn, 1);
    check("go_restart_flag", game_over, 0);
    tick();

    // Extra lives in ALIVE saturate at MAX_LIVES when enabled.
    for (int i = 0; i < 3; i++) begin
      extra_life = 1'b1; tick(); extra_life = 1'b0;
    end
    check("sat_lives", lives, SAT_LIVES);

    // Run down to zero lives, then award a life on the final death frame.
    for (int k = 1; k <= SAT_LIVES; k++) begin
      kill();
      check("run_lives", lives, SAT_LIVES - k);
      if (k < SAT_LIVES) frames(90);
    end
    frames(59);
    startOfFrame = 1'b1; extra_life = 1'b1; tick();
    startOfFrame = 1'b0; extra_life = 1'b0;
    check("xl_end_state", state_dbg, END_STATE);
    check("xl_end_lives", lives, END_LIVES);
    check("xl_end_go", game_over, END_GO);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/player_life_ctrl.md
Name: player_life_ctrl

Overview:
Sequences the player object through its life cycle: alive, dying, waiting, respawn and game over.
- Consumes the player collision/death pulse and frame ticks.
- Drives freeze and respawn controls into the player movement logic.
- Publishes lives count, death-animation flag and game-over flag to the HUD and game FSM.
- Sits between the collision matrix and the player object.

Parameters:
INIT_LIVES, 3, lives loaded on game_start
MAX_LIVES, 5, saturation ceiling for lives
DEATH_FRAMES, 60, frames spent in DYING (death animation)
RESPAWN_FRAMES, 30, frames spent in WAIT before respawn
INVULN_FRAMES, 90, frames after respawn during which player_died is ignored

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
startOfFrame  in  1  one-cycle pulse per video frame
game_start  in  1  one-cycle pulse: new game
player_died  in  1  collision-derived death request, level or pulse
extra_life  in  1  one-cycle pulse: award life (used only with EXTRA_LIFE_EN)
player_freeze  out  1  high: movement logic ignores arrow inputs
player_respawn  out  1  one-cycle pulse: movement logic reloads start position
death_anim  out  1  high while in DYING
invulnerable  out  1  high while invulnerability counter nonzero
lives  out  3  remaining lives, 0..MAX_LIVES
game_over  out  1  high in GAME_OVER
state_dbg  out  3  encoded FSM state

Behaviour:
- Reset (async, active-high) values:
  - state = IDLE; lives = 0.
  - player_freeze = 1; game_over = 0; death_anim = 0.
  - player_respawn = 0; invulnerable = 0.
  - frame counter and invulnerability counter = 0.
- All outputs are registered. Outputs change one clk after the causing input edge.
- States: IDLE(0), ALIVE(1), DYING(2), WAIT(3), RESPAWN(4), GAME_OVER(5).
- IDLE:
  - freeze = 1.
  - On game_start: lives <= INIT_LIVES; state -> RESPAWN.
- RESPAWN:
  - Lasts exactly one clk; player_respawn = 1 during it.
  - Invulnerability counter loaded with INVULN_FRAMES.
  - Next -> ALIVE.
- ALIVE:
  - freeze = 0.
  - If player_died = 1 and invulnerable = 0: lives <= lives - 1; frame counter cleared; state -> DYING.
  - player_died while invulnerable is dropped, not queued.
- DYING:
  - freeze = 1; death_anim = 1.
  - Frame counter increments on each startOfFrame.
  - When the counter reaches DEATH_FRAMES-1 and startOfFrame = 1, counter clears.
    - If lives = 0 -> GAME_OVER.
    - Else -> WAIT.
- WAIT:
  - freeze = 1.
  - Counts RESPAWN_FRAMES startOfFrame pulses the same way, then -> RESPAWN.
- GAME_OVER:
  - freeze = 1; game_over = 1.
  - Holds until game_start, then behaves as the IDLE transition.
- Invulnerability counter: decrements on startOfFrame while nonzero in any state. invulnerable = (counter != 0).
- player_died is ignored in every state except ALIVE.
- game_start has priority in every state: it restarts with lives = INIT_LIVES and goes -> RESPAWN. This includes mid-DYING and mid-WAIT.
- Lives arithmetic:
  - Decrement never wraps below 0. Entering DYING with lives = 1 yields 0, then GAME_OVER.
  - Increment saturates at MAX_LIVES.
- Counter widths: wide enough for max(DEATH_FRAMES, RESPAWN_FRAMES, INVULN_FRAMES). A parameter value of 0 is treated as 1.
- startOfFrame coincident with a state entry does not count toward that state.

Optional Feature:
EXTRA_LIFE_EN
- Defined: an extra_life pulse increments lives (saturating at MAX_LIVES) in ALIVE, DYING, WAIT or RESPAWN.
  - If it coincides with the death decrement, the net change is 0.
  - A life awarded in DYING with lives = 0 prevents GAME_OVER; the block goes to WAIT instead.
- Undefined: the extra_life port exists but is ignored, and lives never increase except via game_start.

Test Plan:
- Reset then game_start -> next clk player_respawn = 1 for exactly 1 clk; lives = 3; then ALIVE, freeze = 0, invulnerable = 1 for 90 frames.
- ALIVE past invulnerability, player_died pulse -> lives = 2, death_anim = 1 for 60 frames, freeze = 1 for 60+30 frames, then player_respawn pulse.
- player_died asserted on frame 10 after respawn -> ignored; lives unchanged; state stays ALIVE.
- Three deaths from lives = 3 -> after the third DYING, game_over = 1, lives = 0. A further player_died has no effect; game_start restores lives = 3 and pulses respawn.
- game_start asserted mid-DYING (frame 20) -> next clk state RESPAWN, lives = 3, death_anim = 0.
- EXTRA_LIFE_EN defined: lives = 5 plus extra_life -> stays 5. extra_life in DYING with lives = 0 -> WAIT, lives = 1. Macro undefined: the same stimulus -> GAME_OVER.
